// File: rtl/median_window_sequencer.sv
// median_window_sequencer
// Sequencing controller for the variable-size median filter datapath.
// Handles the input handshake, tracks window fill, strobes the cell array
// (cell_en / pipe_en / cell_clear), flags valid medians leaving the pipeline
// and performs a drain-and-clear when the window size is changed mid-stream.
// Optional build macro MEDIAN_SEQ_STATS_EN adds the med_cnt / cfg_rej outputs.
module median_window_sequencer #(
   parameter int MAX_N    = 15,
   parameter int CNT_W    = 4,
   parameter int PIPE_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cfg_n,
   input  logic             cfg_load,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             med_valid,
   output logic             cell_en,
   output logic             pipe_en,
   output logic             cell_clear,
   output logic [CNT_W-1:0] win_n,
   output logic [CNT_W-1:0] fill_cnt,
   output logic             busy
`ifdef MEDIAN_SEQ_STATS_EN
   ,
   output logic [15:0]      med_cnt,
   output logic             cfg_rej
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_FLUSH,
      S_CLEAR
   } state_t;

   localparam logic [CNT_W-1:0] WIN_RST  = CNT_W'(3);
   localparam logic [CNT_W-1:0] WIN_MAX  = CNT_W'(MAX_N);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(MAX_N - 1);

   state_t                state_q;
   logic [CNT_W-1:0]      win_q;
   logic [CNT_W-1:0]      fill_q;
   logic [CNT_W-1:0]      pend_n_q;
   logic [CNT_W-1:0]      pend_n_d;
   logic                  pend_q;
   logic [CNT_W-1:0]      clr_cnt_q;
   logic                  cell_clear_q;
   logic                  busy_q;
   logic [PIPE_LAT-1:0]   trk_q;
   logic [PIPE_LAT-1:0]   trk_d;

   logic cfg_ok;
   logic cfg_legal;
   logic accepting_state;
   logic accept;
   logic fill_done;
   logic ins_bit;

   // Window size must be odd and inside [3, MAX_N]; anything else is dropped.
   assign cfg_ok    = cfg_n[0] && (cfg_n >= WIN_RST) && (cfg_n <= WIN_MAX);
   assign cfg_legal = cfg_load && cfg_ok;

   // Whole datapath freezes while a median is presented and not taken.
   assign pipe_en         = !rst && !(med_valid && !out_ready);
   assign accepting_state = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_RUN);
   assign in_ready        = pipe_en && accepting_state && !pend_q;
   assign accept          = in_valid && in_ready;
   assign cell_en         = accept;

   // The accept that brings the window to win_n is the first to yield a median.
   assign fill_done = (state_q == S_FILL) && ((fill_q + CNT_W'(1)) == win_q);
   assign ins_bit   = accept && ((state_q == S_RUN) || fill_done);

   // A late cfg_load in the same cycle still wins over the held pending value.
   assign pend_n_d = cfg_legal ? cfg_n : pend_n_q;

   // Tracker advances with the datapath; its tail marks a valid median.
   assign trk_d = pipe_en ? ((trk_q << 1) | PIPE_LAT'(ins_bit)) : trk_q;

   assign med_valid  = trk_q[PIPE_LAT-1];
   assign cell_clear = cell_clear_q;
   assign busy       = busy_q;
   assign win_n      = win_q;
   assign fill_cnt   = fill_q;

   // Median-in-flight tracker.
   always_ff @(posedge clk) begin
      if (rst) trk_q <= '0;
      else     trk_q <= trk_d;
   end

   // Main sequencing FSM with registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         win_q        <= WIN_RST;
         fill_q       <= '0;
         pend_q       <= 1'b0;
         pend_n_q     <= WIN_RST;
         clr_cnt_q    <= '0;
         cell_clear_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cfg_legal) win_q <= cfg_n;
               if (accept) begin
                  state_q <= S_FILL;
                  fill_q  <= CNT_W'(1);
               end
            end
            S_FILL, S_RUN: begin
               if (accept && state_q == S_FILL) begin
                  fill_q <= fill_q + CNT_W'(1);
                  if (fill_done) state_q <= S_RUN;
               end
               // Reconfig mid-stream: drain in-flight medians before clearing.
               if (cfg_legal) begin
                  pend_q   <= 1'b1;
                  pend_n_q <= cfg_n;
                  state_q  <= S_FLUSH;
                  busy_q   <= 1'b1;
               end
            end
            S_FLUSH: begin
               pend_n_q <= pend_n_d;
               if (trk_q == '0) begin
                  state_q      <= S_CLEAR;
                  cell_clear_q <= 1'b1;
                  clr_cnt_q    <= '0;
               end
            end
            S_CLEAR: begin
               pend_n_q <= pend_n_d;
               if (clr_cnt_q == CLR_LAST) begin
                  state_q      <= S_IDLE;
                  win_q        <= pend_n_d;
                  fill_q       <= '0;
                  pend_q       <= 1'b0;
                  cell_clear_q <= 1'b0;
                  busy_q       <= 1'b0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q      <= S_IDLE;
               cell_clear_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEDIAN_SEQ_STATS_EN
   logic [15:0] med_cnt_q;
   logic        cfg_rej_q;

   assign med_cnt = med_cnt_q;
   assign cfg_rej = cfg_rej_q;

   // Delivered-median counter (wraps) and sticky illegal-config flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         med_cnt_q <= '0;
         cfg_rej_q <= 1'b0;
      end else begin
         if (med_valid && out_ready) med_cnt_q <= med_cnt_q + 16'd1;
         if (cfg_load && !cfg_ok)    cfg_rej_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_median_window_sequencer.sv
// Bench for median_window_sequencer: queue-based reference model of the
// sample/median flow plus directed scenarios and randomized traffic.
module tb_median_window_sequencer;
   localparam int MAX_N = 15;
   localparam int CNT_W = 4;
   localparam int L     = 4;
`ifdef MEDIAN_SEQ_STATS_EN
   localparam int VW = 31;
`else
   localparam int VW = 14;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CNT_W-1:0] cfg_n = '0;
   logic cfg_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, med_valid, cell_en, pipe_en, cell_clear, busy;
   logic [CNT_W-1:0] win_n, fill_cnt;
`ifdef MEDIAN_SEQ_STATS_EN
   logic [15:0] med_cnt;
   logic cfg_rej;
`endif

   median_window_sequencer #(.MAX_N(MAX_N), .CNT_W(CNT_W), .PIPE_LAT(L)) dut (
      .clk(clk), .rst(rst), .cfg_n(cfg_n), .cfg_load(cfg_load),
      .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
      .med_valid(med_valid), .cell_en(cell_en), .pipe_en(pipe_en),
      .cell_clear(cell_clear), .win_n(win_n), .fill_cnt(fill_cnt), .busy(busy)
`ifdef MEDIAN_SEQ_STATS_EN
      , .med_cnt(med_cnt), .cfg_rej(cfg_rej)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [VW-1:0] obs, exp_v;
   bit o_ce, o_mv, o_pe, o_ir, o_clr, o_busy, o_xfer;

   // Reference model: mode 0 idle, 1 fill, 2 run, 3 flush, 4 clear.
   // Each produced median is queued with the enabled-edge count at which it
   // reaches the datapath output.
   int m_mode, m_win, m_fill, m_pend, m_pv, m_clr, en_cnt, m_medcnt;
   bit m_rej;
   int q[$];

   task automatic model_reset();
      m_mode = 0; m_win = 3; m_fill = 0; m_pend = 0; m_pv = 3; m_clr = 0;
      en_cnt = 0; m_medcnt = 0; m_rej = 0;
      q.delete();
   endtask

   // Advance one clock: predict and capture outputs, then step the model.
   task automatic tick();
      bit mv, pe, ir, acc, legal, ok, was_empty, prod;
      #2;
      mv  = (q.size() > 0) && (q[0] == en_cnt);
      pe  = !rst && !(mv && !out_ready);
      ir  = pe && (m_mode <= 2) && (m_pend == 0);
      acc = in_valid && ir;
      exp_v = {ir, acc, pe, mv, (m_mode == 4), (m_mode >= 3), 4'(m_win), 4'(m_fill)
`ifdef MEDIAN_SEQ_STATS_EN
               , 16'(m_medcnt), m_rej
`endif
              };
      obs = {in_ready, cell_en, pipe_en, med_valid, cell_clear, busy, win_n, fill_cnt
`ifdef MEDIAN_SEQ_STATS_EN
             , med_cnt, cfg_rej
`endif
            };
      o_ir = in_ready; o_ce = cell_en; o_pe = pipe_en; o_mv = med_valid;
      o_clr = cell_clear; o_busy = busy; o_xfer = med_valid && out_ready && !rst;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         ok        = (cfg_n % 2 == 1) && (cfg_n >= 3) && (cfg_n <= MAX_N);
         legal     = cfg_load && ok;
         was_empty = (q.size() == 0);
         prod      = acc && (m_mode == 2 || (m_mode == 1 && m_fill + 1 == m_win));
         if (cfg_load && !ok) m_rej = 1;
         if (pe) begin
            en_cnt++;
            if (mv && out_ready) begin
               void'(q.pop_front());
               m_medcnt = (m_medcnt + 1) & 16'hFFFF;
            end
            if (prod) q.push_back(en_cnt + L - 1);
         end
         case (m_mode)
            0: begin
               if (legal) m_win = cfg_n;
               if (acc) begin m_mode = 1; m_fill = 1; end
            end
            1, 2: begin
               if (acc && m_mode == 1) begin
                  m_fill++;
                  if (m_fill == m_win) m_mode = 2;
               end
               if (legal) begin m_pend = 1; m_pv = cfg_n; m_mode = 3; end
            end
            3: begin
               if (legal) m_pv = cfg_n;
               if (was_empty) begin m_mode = 4; m_clr = MAX_N; end
            end
            default: begin
               if (legal) m_pv = cfg_n;
               m_clr--;
               if (m_clr == 0) begin m_mode = 0; m_win = m_pv; m_fill = 0; m_pend = 0; end
            end
         endcase
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      in_valid = 1'b1;
      tick();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL reset_in_rst: got %h want %h", obs, exp_v); end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      n_cmp++;
      if ({o_mv, o_clr, o_busy, win_n, fill_cnt} !== {3'b000, 4'd3, 4'd0}) begin
         n_bad++; $display("FAIL reset_values: got %b want %b", {o_mv, o_clr, o_busy, win_n, fill_cnt}, {3'b000, 4'd3, 4'd0});
      end
   endtask

   task automatic test_cfg_idle_stream();
      int accepts, acc5, first, nmed;
      cfg_n = 4'd5; cfg_load = 1'b1; out_ready = 1'b1;
      tick();
      cfg_load = 1'b0;
      n_cmp++;
      if (win_n !== 4'd5) begin n_bad++; $display("FAIL cfg_idle_win: got %0d want 5", win_n); end
      accepts = 0; acc5 = -1; first = -1; nmed = 0;
      for (int c = 0; c < 40; c++) begin
         in_valid = (accepts < 10);
         tick();
         n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL stream_cyc%0d: got %h want %h", c, obs, exp_v); end
         if (o_ce) begin accepts++; if (accepts == 5) acc5 = c; end
         if (o_mv && first < 0) first = c;
         if (o_xfer) nmed++;
      end
      n_cmp++;
      if (first - acc5 != 4 || acc5 < 0) begin n_bad++; $display("FAIL first_med_lat: got %0d want 4", first - acc5); end
      n_cmp++;
      if (nmed != 6) begin n_bad++; $display("FAIL stream_med_count: got %0d want 6", nmed); end
   endtask

   task automatic test_reconfig_flush();
      int nmed, nclr, med_at_clr;
      bit seen_clr, done;
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (2) begin
         tick();
         n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL reconf_feed: got %h want %h", obs, exp_v); end
      end
      in_valid = 1'b0; cfg_n = 4'd7; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      nmed = 0; nclr = 0; med_at_clr = -1; seen_clr = 0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         tick();
         n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL reconf_cyc%0d: got %h want %h", c, obs, exp_v); end
         if (o_xfer) nmed++;
         if (o_clr) begin
            if (!seen_clr) med_at_clr = nmed;
            seen_clr = 1; nclr++;
         end
         if (seen_clr && !o_busy) done = 1;
      end
      n_cmp++;
      if (!done) begin n_bad++; $display("FAIL reconf_timeout: got busy want idle"); end
      n_cmp++;
      if (med_at_clr != 2 || nmed != 2) begin n_bad++; $display("FAIL reconf_drain: got %0d/%0d want 2/2", med_at_clr, nmed); end
      n_cmp++;
      if (nclr != MAX_N) begin n_bad++; $display("FAIL reconf_clear_len: got %0d want %0d", nclr, MAX_N); end
      n_cmp++;
      if ({win_n, fill_cnt} !== {4'd7, 4'd0}) begin n_bad++; $display("FAIL reconf_final: got %h want 70", {win_n, fill_cnt}); end
   endtask

   task automatic test_stall();
      int accepts, nmed;
      bit stalled;
      cfg_n = 4'd3; cfg_load = 1'b1; in_valid = 1'b0;
      tick();
      cfg_load = 1'b0;
      accepts = 0; nmed = 0; stalled = 0;
      for (int c = 0; c < 40; c++) begin
         in_valid = (c < 20);
         if (!stalled && nmed >= 1 && med_valid) begin
            stalled = 1;
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               n_cmp++;
               if ({o_ir, o_pe, o_mv} !== 3'b001) begin n_bad++; $display("FAIL stall_hold%0d: got %b want 001", s, {o_ir, o_pe, o_mv}); end
            end
            out_ready = 1'b1;
         end
         tick();
         n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL stall_cyc%0d: got %h want %h", c, obs, exp_v); end
         if (o_ce) accepts++;
         if (o_xfer) nmed++;
      end
      n_cmp++;
      if (!stalled || nmed != accepts - 2) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", nmed, accepts - 2); end
   endtask

   task automatic test_illegal_cfg();
      logic [CNT_W-1:0] bad [3];
      bad[0] = 4'd4; bad[1] = 4'd1; bad[2] = 4'd0;   // 17 truncates to 1 in 4 bits
      for (int i = 0; i < 3; i++) begin
         cfg_n = bad[i]; cfg_load = 1'b1;
         tick();
         cfg_load = 1'b0;
         tick();
         n_cmp++;
         if ({o_busy, win_n} !== {1'b0, 4'd3}) begin n_bad++; $display("FAIL illegal_cfg%0d: got %h want 03", i, {o_busy, win_n}); end
      end
`ifdef MEDIAN_SEQ_STATS_EN
      n_cmp++;
      if (cfg_rej !== 1'b1) begin n_bad++; $display("FAIL cfg_rej: got %b want 1", cfg_rej); end
`endif
   endtask

   task automatic test_rst_fill();
      int accepts, acc3, first;
      bit done;
      cfg_n = 4'd5; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         tick();
         if (!o_busy && c > 2) done = 1;
      end
      n_cmp++;
      if (!done || win_n !== 4'd5) begin n_bad++; $display("FAIL rstfill_setup: got %0d want 5", win_n); end
      in_valid = 1'b1;
      repeat (2) tick();
      in_valid = 1'b0;
      n_cmp++;
      if (fill_cnt !== 4'd2) begin n_bad++; $display("FAIL rstfill_fill: got %0d want 2", fill_cnt); end
      rst = 1'b1; in_valid = 1'b1;
      tick();
      n_cmp++;
      if ({o_ir, o_ce, o_pe} !== 3'b000) begin n_bad++; $display("FAIL rst_gating: got %b want 000", {o_ir, o_ce, o_pe}); end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      n_cmp++;
      if ({o_mv, o_clr, o_busy, win_n, fill_cnt} !== {3'b000, 4'd3, 4'd0}) begin
         n_bad++; $display("FAIL rst_after_fill: got %b want %b", {o_mv, o_clr, o_busy, win_n, fill_cnt}, {3'b000, 4'd3, 4'd0});
      end
      accepts = 0; acc3 = -1; first = -1;
      for (int c = 0; c < 15; c++) begin
         in_valid = (accepts < 3);
         tick();
         n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL rstfill_cyc%0d: got %h want %h", c, obs, exp_v); end
         if (o_ce) begin accepts++; if (accepts == 3) acc3 = c; end
         if (o_mv && first < 0) first = c;
      end
      n_cmp++;
      if (acc3 < 0 || first - acc3 != 4) begin n_bad++; $display("FAIL rstfill_first_med: got %0d want 4", first - acc3); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         cfg_load  = ($urandom % 60) == 0;
         cfg_n     = 4'($urandom % 16);
         rst       = ($urandom % 400) == 0;
         tick();
         n_cmp++;
         if (obs !== exp_v) begin n_bad++; if (n_bad < 40) $display("FAIL random_cyc%0d: got %h want %h", c, obs, exp_v); end
      end
      rst = 1'b0; cfg_load = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
   endtask

`ifdef MEDIAN_SEQ_STATS_EN
   task automatic test_wrap();
      int nmed;
      rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; nmed = 0;
      for (int c = 0; c < 65600 && nmed < 65537; c++) begin
         tick();
         if (o_xfer) nmed++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      n_cmp++;
      if (nmed != 65537 || med_cnt !== 16'd1) begin n_bad++; $display("FAIL med_cnt_wrap: got %0d after %0d want 1", med_cnt, nmed); end
   endtask
`endif

   initial begin
      test_reset();
      test_cfg_idle_stream();
      test_reconfig_flush();
      test_stall();
      test_illegal_cfg();
      test_rst_fill();
      test_random();
`ifdef MEDIAN_SEQ_STATS_EN
      test_wrap();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
